fifo_fwft_sync: RTL and testbench

Single-clock first-word-fall-through FIFO controller built around a 2-port synchronous memory. The write side stores through a write port. The read side issues registered-address reads with 1-cycle latency and presents the head word through a two-entry output stage, so `rd_data` is valid whenever `rd_valid` is high. It sits between byte/word producers and consumers, for example UART, SPI and DMA paths, where a plain registered-read RAM cannot give show-ahead data.

---
 rtl/fifo_fwft_sync.sv | 126 ++++++++++++
 tb/tb_fifo_fwft_sync.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_sync.sv
// First-word-fall-through FIFO over a registered-read 2-port memory.
// A two-entry head/skid stage hides the memory read latency from the consumer.
module fifo_fwft_sync #(
  parameter int DATA = 8,
  parameter int ADDR = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  output logic            full,
  output logic            overflow,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            rd_valid,
  output logic            underflow,
  output logic [ADDR:0]   level
);

  localparam int            DEPTH      = 2 ** ADDR;
  localparam logic [ADDR:0] FULL_LEVEL = {1'b1, {ADDR{1'b0}}};

  logic [DATA-1:0] mem [DEPTH];

  logic [ADDR-1:0] wptr_q, wptr_d;
  logic [ADDR-1:0] rptr_q, rptr_d;
  logic [ADDR-1:0] raddr_q, raddr_d;
  logic [ADDR:0]   memCount_q, memCount_d;
  logic [ADDR:0]   level_q, level_d;
  logic            inflight_q, inflight_d;
  logic            headV_q, headV_d;
  logic            skidV_q, skidV_d;
  logic [DATA-1:0] head_q, head_d;
  logic [DATA-1:0] skid_q, skid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            push;
  logic            pop;
  logic            fetch;
  logic [2:0]      occupancy;
  logic [DATA-1:0] memRdata;

  assign memRdata = mem[raddr_q];
  assign full     = (level_q == FULL_LEVEL);

  always_comb begin
    push      = wr_en && !full;
    pop       = rd_en && headV_q;
    occupancy = {2'b00, headV_q} + {2'b00, skidV_q} + {2'b00, inflight_q};
    // A word pushed while memCount_q is 0 is only fetchable next cycle.
    fetch     = (memCount_q != '0) && ((occupancy - {2'b00, pop}) < 3'd2);

    wptr_d      = push  ? wptr_q + {{(ADDR-1){1'b0}}, 1'b1} : wptr_q;
    rptr_d      = fetch ? rptr_q + {{(ADDR-1){1'b0}}, 1'b1} : rptr_q;
    raddr_d     = fetch ? rptr_q : raddr_q;
    memCount_d  = memCount_q + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, fetch};
    level_d     = level_q + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, pop};
    inflight_d  = fetch;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && !headV_q;

    head_d  = head_q;
    headV_d = headV_q;
    skid_d  = skid_q;
    skidV_d = skidV_q;
    if (pop) begin
      head_d  = skid_q;
      headV_d = skidV_q;
      skidV_d = 1'b0;
    end
    // The landing word takes the first free slot so order is preserved.
    if (inflight_q) begin
      if (!headV_d) begin
        head_d  = memRdata;
        headV_d = 1'b1;
      end else begin
        skid_d  = memRdata;
        skidV_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      raddr_q     <= '0;
      memCount_q  <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      headV_q     <= 1'b0;
      skidV_q     <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      raddr_q     <= raddr_d;
      memCount_q  <= memCount_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      headV_q     <= headV_d;
      skidV_q     <= skidV_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data   = head_q;
  assign rd_valid  = headV_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fifo_fwft_sync.sv
// Bench for fifo_fwft_sync: vector table, directed corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_fifo_fwft_sync;

  localparam int DATA  = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [DATA-1:0] wr_data = '0;
  logic            full;
  logic            overflow;
  logic            rd_en = 1'b0;
  logic [DATA-1:0] rd_data;
  logic            rd_valid;
  logic            underflow;
  logic [ADDR:0]   level;

  fifo_fwft_sync #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .underflow(underflow), .level(level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue holds every word; the first mStage are visible, the next
  // mFlight are being read, the rest sit in memory.
  logic [DATA-1:0] q[$];
  int mStage = 0;
  int mFlight = 0;
  logic mOvf = 1'b0;
  logic mUnf = 1'b0;

  typedef struct {
    logic            wr;
    logic [DATA-1:0] wdata;
    logic            rd;
    logic            expValid;
    logic [DATA-1:0] expData;
    int              expLevel;
    logic            expFull;
    logic            expOvf;
    logic            expUnf;
  } vec_t;

  vec_t vecs[8];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    q.delete();
    mStage = 0;
    mFlight = 0;
    mOvf = 1'b0;
    mUnf = 1'b0;
  endfunction

  function automatic void modelStep(input logic wr, input logic [DATA-1:0] d, input logic rd);
    int  sz     = q.size();
    bit  pushOk = wr && (sz < DEPTH);
    bit  popOk  = rd && (mStage > 0);
    int  inMem  = sz - mStage - mFlight;
    bit  fetch  = (inMem > 0) && ((mStage + mFlight - int'(popOk)) < 2);
    mOvf = wr && (sz == DEPTH);
    mUnf = rd && (mStage == 0);
    if (popOk) begin
      void'(q.pop_front());
      mStage--;
    end
    mStage += mFlight;
    mFlight = fetch ? 1 : 0;
    if (pushOk) q.push_back(d);
  endfunction

  task automatic applyStimulus(input logic wr, input logic [DATA-1:0] d, input logic rd);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    modelStep(wr, d, rd);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " rd_valid"}, {31'b0, rd_valid}, {31'b0, mStage > 0});
    if (mStage > 0) checkVal({tag, " rd_data"}, {24'b0, rd_data}, {24'b0, q[0]});
    checkVal({tag, " level"}, {27'b0, level}, q.size());
    checkVal({tag, " full"}, {31'b0, full}, {31'b0, q.size() == DEPTH});
    checkVal({tag, " overflow"}, {31'b0, overflow}, {31'b0, mOvf});
    checkVal({tag, " underflow"}, {31'b0, underflow}, {31'b0, mUnf});
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, " rd_valid"}, {31'b0, rd_valid}, 0);
    checkVal({tag, " rd_data"}, {24'b0, rd_data}, 0);
    checkVal({tag, " level"}, {27'b0, level}, 0);
    checkVal({tag, " full"}, {31'b0, full}, 0);
    checkVal({tag, " overflow"}, {31'b0, overflow}, 0);
    checkVal({tag, " underflow"}, {31'b0, underflow}, 0);
  endtask

  task automatic resetDut(input string tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #2;
    modelReset();
    checkResetValues(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pops (if any) happen at the coming edge; returns the word leaving.
  task automatic stepAndScore(input logic wr, input logic [DATA-1:0] d, input logic rd,
                              input string tag, inout int popCount, inout int expNext);
    if (rd && rd_valid) begin
      checkVal({tag, " pop order"}, {24'b0, rd_data}, expNext[7:0]);
      popCount++;
      expNext++;
    end
    applyStimulus(wr, d, rd);
    checkOutput(tag);
  endtask

  initial begin
    int pops, nextVal, cyc, firstPop, lastPop, maxLevel, wrPct, rdPct;
    logic [3:0] rdPattern;

    // Test 1 (single word latency) followed by test 4 (underflow on empty).
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};

    resetDut("reset");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wdata, vecs[i].rd);
      checkVal($sformatf("vec%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].expValid});
      if (vecs[i].expValid) checkVal($sformatf("vec%0d rd_data", i), {24'b0, rd_data}, {24'b0, vecs[i].expData});
      checkVal($sformatf("vec%0d level", i), {27'b0, level}, vecs[i].expLevel);
      checkVal($sformatf("vec%0d full", i), {31'b0, full}, {31'b0, vecs[i].expFull});
      checkVal($sformatf("vec%0d overflow", i), {31'b0, overflow}, {31'b0, vecs[i].expOvf});
      checkVal($sformatf("vec%0d underflow", i), {31'b0, underflow}, {31'b0, vecs[i].expUnf});
    end

    // Fill to full, drop one push, then drain in order.
    resetDut("reset fill");
    pops = 0;
    nextVal = 0;
    for (int i = 0; i < DEPTH; i++) stepAndScore(1'b1, 8'(i), 1'b0, "fill", pops, nextVal);
    checkVal("fill full", {31'b0, full}, 1);
    checkVal("fill level", {27'b0, level}, DEPTH);
    stepAndScore(1'b1, 8'hFF, 1'b0, "overflow", pops, nextVal);
    checkVal("overflow pulse", {31'b0, overflow}, 1);
    stepAndScore(1'b0, 8'h00, 1'b0, "overflow end", pops, nextVal);
    checkVal("overflow one cycle", {31'b0, overflow}, 0);
    for (int i = 0; i < 40 && q.size() > 0; i++) stepAndScore(1'b0, 8'h00, 1'b1, "drain", pops, nextVal);
    checkVal("drain count", pops, DEPTH);
    checkVal("drain empty level", {27'b0, level}, 0);
    checkVal("drain empty valid", {31'b0, rd_valid}, 0);
    rd_en = 1'b0;

    // Continuous push and pop across pointer wraps.
    resetDut("reset stream");
    pops = 0;
    nextVal = 0;
    firstPop = -1;
    lastPop = -1;
    maxLevel = 0;
    for (cyc = 0; cyc < 60 && pops < 40; cyc++) begin
      if (rd_valid) begin
        if (firstPop < 0) firstPop = cyc;
        lastPop = cyc;
      end
      stepAndScore(cyc < 40, 8'(cyc), 1'b1, "stream", pops, nextVal);
      if (int'(level) > maxLevel) maxLevel = int'(level);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    checkVal("stream count", pops, 40);
    checkVal("stream no bubbles", lastPop - firstPop, 39);
    checkVal("stream level bound", {31'b0, maxLevel <= 3}, 1);

    // Pushes every cycle, pops on a 1,0,0,1 pattern until full.
    resetDut("reset skid");
    pops = 0;
    nextVal = 0;
    rdPattern = 4'b1001;
    for (cyc = 0; cyc < 200 && q.size() < DEPTH; cyc++)
      stepAndScore(1'b1, 8'(cyc), rdPattern[cyc % 4], "skid", pops, nextVal);
    checkVal("skid reached full", {31'b0, full}, 1);
    for (int i = 0; i < 60 && q.size() > 0; i++) stepAndScore(1'b0, 8'h00, 1'b1, "skid drain", pops, nextVal);
    checkVal("skid no loss", pops, cyc);
    rd_en = 1'b0;

    // Asynchronous reset with a read outstanding.
    resetDut("reset async");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pre async");
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkResetValues("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkVal("post reset valid", {31'b0, rd_valid}, 1);
    checkVal("post reset data", {24'b0, rd_data}, 8'h3C);
    checkVal("post reset level", {27'b0, level}, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkVal("post reset no stale", {31'b0, rd_valid}, 0);
    checkOutput("post reset");

    // Randomized traffic with shifting write/read pressure.
    resetDut("reset random");
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        wrPct = $urandom_range(10, 95);
        rdPct = $urandom_range(10, 95);
      end
      applyStimulus($urandom_range(0, 99) < wrPct, 8'($urandom), $urandom_range(0, 99) < rdPct);
      checkOutput("random");
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
